// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler owning the select of an 8:1 bit mux; grants bursts of up to MAX_BURST cycles.
// Optional ARB_MASK_EN adds a req_mask input that removes channels from arbitration.
module mux8_rr_scheduler #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
`ifdef ARB_MASK_EN
  input  logic [7:0] req_mask,
`endif
  input  logic [7:0] in,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       valid,
  output logic       y
);

  localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state;
  logic [2:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_grant;
  logic [2:0]    r_sel;
  logic          r_valid;
  logic          r_y;

  logic [7:0]    w_elig;
  logic          w_release;
  logic [2:0]    w_search_ptr;
  logic          w_found;
  logic [2:0]    w_winner;

`ifdef ARB_MASK_EN
  assign w_elig = req & ~req_mask;
`else
  assign w_elig = req;
`endif

  // On release the search already starts at sel+1, so handoff needs no idle cycle.
  always_comb begin
    logic [2:0] idx;
    idx          = '0;
    w_release    = (r_state == S_GRANT) && (!w_elig[r_sel] || (r_cnt == LAST));
    w_search_ptr = w_release ? (r_sel + 3'd1) : r_ptr;
    w_found      = 1'b0;
    w_winner     = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = w_search_ptr + 3'(k);
      if (!w_found && w_elig[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_y     <= 1'b0;
    end else begin
      r_y <= r_valid ? in[r_sel] : 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_sel   <= w_winner;
            r_grant <= 8'b1 << w_winner;
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_grant <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
          end
        end
        S_GRANT: begin
          if (!w_release) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_ptr <= r_sel + 3'd1;
            r_cnt <= '0;
            if (w_found) begin
              r_sel   <= w_winner;
              r_grant <= 8'b1 << w_winner;
            end else begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_sel   <= '0;
              r_valid <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign valid = r_valid;
  assign y     = r_y;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: two instances (MAX_BURST 16 and 2) checked against a channel-level model.
module tb_mux8_rr_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] in;
`ifdef ARB_MASK_EN
  logic [7:0] req_mask;
`endif

  logic [7:0] grant16, grant2;
  logic [2:0] sel16, sel2;
  logic       valid16, valid2;
  logic       y16, y2;

  int checks = 0;
  int errors = 0;

  mux8_rr_scheduler #(.MAX_BURST(16)) u_dut16 (
    .clk(clk), .rst(rst), .req(req),
`ifdef ARB_MASK_EN
    .req_mask(req_mask),
`endif
    .in(in), .grant(grant16), .sel(sel16), .valid(valid16), .y(y16)
  );

  mux8_rr_scheduler #(.MAX_BURST(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req),
`ifdef ARB_MASK_EN
    .req_mask(req_mask),
`endif
    .in(in), .grant(grant2), .sel(sel2), .valid(valid2), .y(y2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: which channel holds the mux (-1 = none), cycles it has held it, rotation start.
  int m_hold [2];
  int m_run  [2];
  int m_ptr  [2];
  bit m_y    [2];
  int m_mb   [2] = '{16, 2};

  function automatic int pick(input logic [7:0] e, input int p);
    for (int k = 0; k < 8; k++)
      if (e[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_hold[m] = -1; m_run[m] = 0; m_ptr[m] = 0; m_y[m] = 1'b0;
    end
  endtask

  task automatic model_tick();
    logic [7:0] e;
`ifdef ARB_MASK_EN
    e = req & ~req_mask;
`else
    e = req;
`endif
    for (int m = 0; m < 2; m++) begin
      m_y[m] = (m_hold[m] >= 0) ? in[m_hold[m]] : 1'b0;
      if (m_hold[m] < 0) begin
        m_hold[m] = pick(e, m_ptr[m]);
        m_run[m]  = 1;
      end else if (!e[m_hold[m]] || m_run[m] >= m_mb[m]) begin
        m_ptr[m]  = (m_hold[m] + 1) % 8;
        m_hold[m] = pick(e, m_ptr[m]);
        m_run[m]  = 1;
      end else begin
        m_run[m]++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] g [2];
    logic [2:0] s [2];
    logic       v [2];
    logic       yy[2];
    g[0] = grant16; s[0] = sel16; v[0] = valid16; yy[0] = y16;
    g[1] = grant2;  s[1] = sel2;  v[1] = valid2;  yy[1] = y2;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s.mb%0d.valid", tag, m_mb[m]), 32'(v[m]), 32'(m_hold[m] >= 0));
      chk($sformatf("%s.mb%0d.grant", tag, m_mb[m]), 32'(g[m]),
          (m_hold[m] >= 0) ? (32'd1 << m_hold[m]) : 32'd0);
      chk($sformatf("%s.mb%0d.sel", tag, m_mb[m]), 32'(s[m]),
          (m_hold[m] >= 0) ? 32'(m_hold[m]) : 32'd0);
      chk($sformatf("%s.mb%0d.y", tag, m_mb[m]), 32'(yy[m]), 32'(m_y[m]));
    end
  endtask

  task automatic step(input string tag);
    model_tick();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    in  = '0;
`ifdef ARB_MASK_EN
    req_mask = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    do_reset();

    // Async reset mid-grant on channel 5
    req = 8'h20;
    step("pre_rst");
    step("pre_rst");
    chk("midgrant.sel", 32'(sel16), 32'd5);
    rst = 1'b1;
    #1;
    chk("async_rst.grant", 32'(grant16), 32'd0);
    chk("async_rst.sel", 32'(sel16), 32'd0);
    chk("async_rst.valid", 32'(valid16), 32'd0);
    chk("async_rst.y", 32'(y16), 32'd0);
    model_reset();
    check_model("async_rst");
    @(negedge clk);
    rst = 1'b0;
    req = '0;

    // Single requester: held continuously, re-granted across burst boundaries
    do_reset();
    req = 8'h08;
    step("single");
    chk("single.grant", 32'(grant16), 32'h08);
    chk("single.sel", 32'(sel16), 32'd3);
    for (int i = 0; i < 40; i++) begin
      step("single_hold");
      chk("single_hold.valid", 32'(valid16), 32'd1);
    end

    // All requesting with MAX_BURST=2: 0,0,1,1,...,7,7,0
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      step("rr");
      chk("rr.sel2", 32'(sel2), 32'((k / 2) % 8));
      chk("rr.valid2", 32'(valid2), 32'd1);
    end

    // Early drop hands off to ch6, then idle
    do_reset();
    req = 8'h44;
    step("drop");
    chk("drop.first", 32'(sel16), 32'd2);
    req = 8'h40;
    step("drop");
    chk("drop.handoff", 32'(sel16), 32'd6);
    req = 8'h00;
    step("drop");
    chk("drop.idle_valid", 32'(valid16), 32'd0);
    chk("drop.idle_grant", 32'(grant16), 32'd0);

    // Data path on ch4
    do_reset();
    req = 8'h10;
    in  = 8'h00;
    step("data");
    in = 8'h10;
    step("data");
    chk("data.y1", 32'(y16), 32'd1);
    in = 8'h00;
    step("data");
    chk("data.y0", 32'(y16), 32'd0);
    req = 8'h00;
    in  = 8'hFF;
    step("data_idle");
    for (int i = 0; i < 4; i++) begin
      step("data_idle");
      chk("data_idle.y", 32'(y16), 32'd0);
    end

`ifdef ARB_MASK_EN
    do_reset();
    req = 8'h03;
    req_mask = 8'h01;
    step("mask");
    chk("mask.sel", 32'(sel16), 32'd1);
    req_mask = 8'h02;
    step("mask");
    chk("mask.handoff", 32'(sel16), 32'd0);
    req_mask = 8'h00;
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) req = 8'($urandom) & 8'($urandom);
      in = 8'($urandom);
`ifdef ARB_MASK_EN
      if ($urandom_range(7) == 0) req_mask = 8'($urandom) & 8'($urandom);
`endif
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
